// File: rtl/uart_bus_bridge_if.sv
// Single-cycle memory-mapped bus shared by the core and the UART bridge.
// The initiator drives the strobe, address, data and size. The responder returns read data.
interface uart_bus_bridge_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  funct3;
    logic [31:0] rd;

    modport master (output we, output a, output wd, output funct3, input rd);
    modport slave  (input we, input a, input wd, input funct3, output rd);
endinterface

// File: rtl/uart_bus_bridge.sv
// UART-to-bus initiator: decodes 8N1 read/write command frames from a host, issues one
// word access on the memory-mapped bus and replies over tx.
module uart_bus_bridge #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    output logic              tx,
    output logic              busy,
    uart_bus_bridge_if.master bus
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned     ToW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      OpWrite  = 8'h57;
    localparam logic [7:0]      OpRead   = 8'h52;
    localparam logic [7:0]      WrAck    = 8'h4B;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {PIdle, PAddr, PData, PExec, PResp} p_state_e;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    p_state_e        p_state_q, p_state_d;
    logic [1:0]      p_cnt_q, p_cnt_d;
    logic            is_wr_q, is_wr_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     wd_q, wd_d;
    logic            tx_start;

    logic            tx_active_q, tx_active_d;
    logic [9:0]      tx_frame_q, tx_frame_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [1:0]      tx_left_q, tx_left_d;
    logic [31:0]     resp_q, resp_d;
    logic            tx_done;

    // Receiver: edge-triggered start, then sample at mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_state_d = RxIdle;
                    rx_valid_d = rx_s2_q;
                    rx_ferr_d  = !rx_s2_q;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Parser: bytes are only consumed while collecting a command.
    always_comb begin
        p_state_d = p_state_q;
        p_cnt_d   = p_cnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        to_cnt_d  = '0;
        a_d       = a_q;
        wd_d      = wd_q;
        tx_start  = 1'b0;
        unique case (p_state_q)
            PIdle: begin
                if (rx_valid_q && (rx_shift_q == OpWrite || rx_shift_q == OpRead)) begin
                    is_wr_d   = (rx_shift_q == OpWrite);
                    p_cnt_d   = '0;
                    p_state_d = PAddr;
                end
            end
            PAddr, PData: begin
                if (rx_ferr_q) begin
                    p_state_d = PIdle;
                end else if (rx_valid_q) begin
                    p_cnt_d = p_cnt_q + 2'd1;
                    if (p_state_q == PAddr) addr_d = {addr_q[23:0], rx_shift_q};
                    else                    data_d = {data_q[23:0], rx_shift_q};
                    if (p_cnt_q == 2'd3) begin
                        if (p_state_q == PAddr && is_wr_q) begin
                            p_state_d = PData;
                        end else begin
                            p_state_d = PExec;
                            a_d       = (p_state_q == PAddr) ? {addr_q[23:0], rx_shift_q} : addr_q;
                            if (p_state_q == PData) wd_d = {data_q[23:0], rx_shift_q};
                        end
                    end
                end else if (to_cnt_q == ToLast) begin
                    p_state_d = PIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            PExec: begin
                tx_start  = 1'b1;
                p_state_d = PResp;
            end
            PResp: if (tx_done) p_state_d = PIdle;
            default: p_state_d = PIdle;
        endcase
    end

    assign tx_done = tx_active_q && (tx_cnt_q == BitLast) && (tx_bit_q == 4'd9) &&
                     (tx_left_q == 2'd0);

    // Transmitter: frame[0] is the current line level; stop bits shift in ones.
    always_comb begin
        tx_active_d = tx_active_q;
        tx_frame_d  = tx_frame_q;
        tx_bit_d    = tx_bit_q;
        tx_cnt_d    = tx_cnt_q + CntW'(1);
        tx_left_d   = tx_left_q;
        resp_d      = resp_q;
        if (tx_start) begin
            tx_active_d = 1'b1;
            tx_bit_d    = '0;
            tx_cnt_d    = '0;
            if (is_wr_q) begin
                tx_frame_d = {1'b1, WrAck, 1'b0};
                tx_left_d  = 2'd0;
            end else begin
                tx_frame_d = {1'b1, bus.rd[31:24], 1'b0};
                resp_d     = {bus.rd[23:0], 8'h00};
                tx_left_d  = 2'd3;
            end
        end else if (tx_active_q) begin
            if (tx_cnt_q == BitLast) begin
                tx_cnt_d = '0;
                if (tx_bit_q != 4'd9) begin
                    tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                end else if (tx_left_q == 2'd0) begin
                    tx_active_d = 1'b0;
                end else begin
                    tx_frame_d = {1'b1, resp_q[31:24], 1'b0};
                    resp_d     = {resp_q[23:0], 8'h00};
                    tx_left_d  = tx_left_q - 2'd1;
                    tx_bit_d   = '0;
                end
            end
        end else begin
            tx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_ferr_q   <= 1'b0;
            p_state_q   <= PIdle;
            p_cnt_q     <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            to_cnt_q    <= '0;
            a_q         <= '0;
            wd_q        <= '0;
            tx_active_q <= 1'b0;
            tx_frame_q  <= '1;
            tx_bit_q    <= '0;
            tx_cnt_q    <= '0;
            tx_left_q   <= '0;
            resp_q      <= '0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            rx_ferr_q   <= rx_ferr_d;
            p_state_q   <= p_state_d;
            p_cnt_q     <= p_cnt_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            to_cnt_q    <= to_cnt_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            tx_active_q <= tx_active_d;
            tx_frame_q  <= tx_frame_d;
            tx_bit_q    <= tx_bit_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_left_q   <= tx_left_d;
            resp_q      <= resp_d;
        end
    end

    assign tx         = tx_frame_q[0];
    assign busy       = (p_state_q != PIdle);
    assign bus.we     = (p_state_q == PExec) && is_wr_q;
    assign bus.a      = a_q;
    assign bus.wd     = wd_q;
    assign bus.funct3 = 3'b010;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: host-side UART driver/decoder, a small bus responder and a
// reference memory model; table vectors, random commands and corner-case sequences.
module tb_uart_bus_bridge;

    localparam int unsigned CPB      = 4;
    localparam int unsigned TO       = 200;
    localparam logic [31:0] Scramble = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic tx;
    logic busy;

    uart_bus_bridge_if bus ();

    uart_bus_bridge #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .tx      (tx),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Responder: 0x1000 reads 0xB, written words read back, others read address ^ Scramble.
    logic [31:0] rmem [64];
    logic [63:0] rvld;
    always @(posedge clk) begin
        if (!reset_n) rvld <= '0;
        else if (bus.we) begin
            rmem[bus.a[7:2]] <= bus.wd;
            rvld[bus.a[7:2]] <= 1'b1;
        end
    end
    always_comb begin
        if (bus.a == 32'h0000_1000)  bus.rd = 32'h0000_000B;
        else if (rvld[bus.a[7:2]])   bus.rd = rmem[bus.a[7:2]];
        else                         bus.rd = bus.a ^ Scramble;
    end

    // Monitors sampled on the falling edge.
    int          cyc = 0;
    int          we_count = 0;
    int          we_cyc = 0;
    int          busy_cycles = 0;
    int          tx_low_cycles = 0;
    int          busy_fall_cyc = 0;
    logic        busy_prev = 1'b0;
    logic [31:0] last_a = '0;
    logic [31:0] last_wd = '0;
    logic [7:0]  tx_bytes [$];
    int          tx_starts [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.we) begin
            we_count <= we_count + 1;
            we_cyc   <= cyc;
            last_a   <= bus.a;
            last_wd  <= bus.wd;
        end
        if (busy) busy_cycles <= busy_cycles + 1;
        if (!tx) tx_low_cycles <= tx_low_cycles + 1;
        if (busy_prev && !busy) busy_fall_cyc <= cyc;
        busy_prev <= busy;
    end

    initial begin : tx_decoder
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx) begin
                tx_starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                tx_bytes.push_back(b);
            end
            prev = tx;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_cmd(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
        send_byte(is_wr ? 8'h57 : 8'h52, 1'b0);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], 1'b0);
        if (is_wr) for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8], 1'b0);
    endtask

    // Full command with reply decode and timing checks.
    task automatic run_cmd(input string tag, input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_rd);
        int         nb, we0, base, k;
        logic [7:0] exp_b;
        nb   = is_wr ? 1 : 4;
        we0  = we_count;
        base = tx_bytes.size();
        send_cmd(is_wr, addr, data);
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy_drop"}, {31'b0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check({tag, "_we_pulses"}, we_count - we0, is_wr ? 32'd1 : 32'd0);
        if (is_wr) begin
            check({tag, "_a"}, last_a, addr);
            check({tag, "_wd"}, last_wd, data);
        end
        check({tag, "_nbytes"}, tx_bytes.size() - base, nb);
        for (int i = 0; i < nb; i++) begin
            exp_b = is_wr ? 8'h4B : exp_rd[8*(3-i) +: 8];
            if (base + i < tx_bytes.size()) check({tag, "_byte"}, {24'b0, tx_bytes[base+i]}, {24'b0, exp_b});
        end
        if (tx_starts.size() == base + nb) begin
            for (int i = 1; i < nb; i++)
                check({tag, "_b2b"}, tx_starts[base+i] - tx_starts[base+i-1], 10 * CPB);
            check({tag, "_reply_span"}, busy_fall_cyc - tx_starts[base], 10 * CPB * nb);
            if (is_wr) check({tag, "_tx_after_we"}, tx_starts[base] - we_cyc, 32'd1);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        int base, we0, bc0, tl0, fall_at;

        vecs[0] = '{1'b1, 32'h0000_1004, 32'h0000_000A, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_000B};
        vecs[2] = '{1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_2008, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'hC000_00F0, 32'h0,         32'h9A5A_00F0};
        vecs[5] = '{1'b1, 32'h0000_1004, 32'h1234_5678, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_1004, 32'h0,         32'h1234_5678};

        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_we", {31'b0, bus.we}, 32'd0);
        check("rst_a", bus.a, 32'd0);
        check("rst_wd", bus.wd, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_funct3", {29'b0, bus.funct3}, 32'd2);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_cmd(vecs[i].is_wr ? "vec_wr" : "vec_rd", vecs[i].is_wr, vecs[i].addr,
                    vecs[i].data, vecs[i].exp_rd);

        // Garbage byte and a short glitch must not start anything.
        bc0 = busy_cycles;
        tl0 = tx_low_cycles;
        send_byte(8'h13, 1'b0);
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("noise_busy_cycles", busy_cycles - bc0, 32'd0);
        check("noise_tx_low_cycles", tx_low_cycles - tl0, 32'd0);
        run_cmd("noise_rd", 1'b0, 32'h0000_1000, 32'h0, 32'h0000_000B);

        // Framing error on the second byte abandons the command.
        we0 = we_count;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("frm_busy_clear", {31'b0, busy}, 32'd0);
        run_cmd("frm_wr", 1'b1, 32'h0000_2010, 32'hCAFE_F00D, 32'h0);
        check("frm_total_we", we_count - we0, 32'd1);

        // Inter-byte timeout.
        we0  = we_count;
        base = tx_bytes.size();
        send_byte(8'h52, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("to_busy_held", {31'b0, busy}, 32'd1);
        fall_at = -1;
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk);
            if (!busy && fall_at < 0) fall_at = i;
        end
        if (fall_at < 196 || fall_at > 206) begin
            n_checks++;
            n_errors++;
            $display("FAIL to_fall_window: busy fell at gap cycle %0d, required near %0d",
                     fall_at, TO);
        end else begin
            n_checks++;
        end
        bc0 = busy_cycles;
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (20) @(negedge clk);
        check("to_late_bytes_busy", busy_cycles - bc0, 32'd0);
        check("to_no_we", we_count - we0, 32'd0);
        check("to_no_reply", tx_bytes.size() - base, 32'd0);

        // Random commands against the reference memory.
        for (int t = 0; t < 16; t++) begin
            bit          w;
            logic [31:0] ad, dt, ex;
            w = 1'($urandom_range(0, 1));
            if (w) begin
                ad = 32'h0000_2040 + 32'(4 * $urandom_range(0, 15));
                dt = $urandom;
                ref_mem[ad] = dt;
                run_cmd("rnd_wr", 1'b1, ad, dt, 32'h0);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    ad = 32'h0000_2040 + 32'(4 * $urandom_range(0, 15));
                end else begin
                    ad = $urandom;
                    ad[7:6] = 2'b11;
                    ad[1:0] = 2'b00;
                end
                ex = ref_mem.exists(ad) ? ref_mem[ad] : (ad ^ Scramble);
                run_cmd("rnd_rd", 1'b0, ad, 32'h0, ex);
            end
        end

        // Reset during the second reply byte.
        base = tx_bytes.size();
        send_cmd(1'b0, 32'h0000_1000, 32'h0);
        for (int k = 0; k < 600 && tx_bytes.size() <= base; k++) @(negedge clk);
        check("rstmid_first_byte", {24'b0, (tx_bytes.size() > base) ? tx_bytes[base] : 8'hFF},
              32'h0);
        repeat (10) @(negedge clk);
        check("rstmid_pre_a", bus.a, 32'h0000_1000);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rstmid_tx", {31'b0, tx}, 32'd1);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_a", bus.a, 32'd0);
        repeat (60) @(negedge clk);
        run_cmd("rstmid_rd", 1'b0, 32'h0000_1000, 32'h0, 32'h0000_000B);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
